// File: rtl/sobel_window_stream_if.sv
// Pixel-in / result-out stream bundle for sobel_window_stream.
// Signal suffixes are from the Sobel block's point of view.
interface sobel_window_stream_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   px_valid_i;
  logic [PIXEL_WIDTH-1:0] px_data_i;
  logic                   px_ready_o;
  logic                   out_valid_o;
  logic [PIXEL_WIDTH-1:0] out_px_o;
  logic                   out_ready_i;

  modport slave (
    input  px_valid_i,
    input  px_data_i,
    input  out_ready_i,
    output px_ready_o,
    output out_valid_o,
    output out_px_o
  );

  modport master (
    output px_valid_i,
    output px_data_i,
    output out_ready_i,
    input  px_ready_o,
    input  out_valid_o,
    input  out_px_o
  );
endinterface

// File: rtl/sobel_window_stream.sv
// Sobel 3x3 window collector over a vertical strip with a
// valid/ready stream, saturated or thresholded edge output.
module sobel_window_stream #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int WIN_CNT_BITS = 10
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [WIN_CNT_BITS-1:0] strip_windows_i,
  input  logic                    mode_i,
  input  logic [PIXEL_WIDTH-1:0]  threshold_i,
  sobel_window_stream_if.slave    s,
  output logic                    busy_o,
  output logic                    strip_done_o
);

  localparam int W = PIXEL_WIDTH + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_SLIDE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [PIXEL_WIDTH-1:0]  p_q [9];
  logic [WIN_CNT_BITS-1:0] wl_q, wl_eff;
  logic                    mode_q;
  logic [PIXEL_WIDTH-1:0]  thr_q;
  logic                    pend_q, pend_d;
  logic                    ov_q;
  logic [PIXEL_WIDTH-1:0]  opx_q;
  logic                    done_q;

  logic out_load, px_acc, last_px, final_win, collecting;

  logic signed [W-1:0]    e [9];
  logic signed [W-1:0]    gx, gy;
  logic [W-1:0]           ax, ay, mag;
  logic [PIXEL_WIDTH-1:0] res;

  assign collecting = (state_q == S_FILL) || (state_q == S_SLIDE);
  assign out_load   = pend_q && (!ov_q || s.out_ready_i);
  assign s.px_ready_o = collecting && (!pend_q || out_load);
  assign px_acc     = s.px_valid_i && s.px_ready_o;
  assign last_px    = (state_q == S_FILL) ? (cnt_q == 4'd8)
                                          : (cnt_q == 4'd2);
  // windows still owed once a same-edge move to the output is counted
  assign wl_eff     = wl_q - WIN_CNT_BITS'(out_load);
  assign final_win  = (wl_eff == WIN_CNT_BITS'(1));
  assign pend_d     = (pend_q && !out_load) || (px_acc && last_px);

  assign s.out_valid_o = ov_q;
  assign s.out_px_o    = opx_q;
  assign busy_o        = (state_q != S_IDLE);
  assign strip_done_o  = done_q;

  // gradient magnitude of the current window, then output mapping
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      e[i] = $signed({3'b000, p_q[i]});
    end
    gx  = (e[2] + (e[5] <<< 1) + e[8]) - (e[0] + (e[3] <<< 1) + e[6]);
    gy  = (e[6] + (e[7] <<< 1) + e[8]) - (e[0] + (e[1] <<< 1) + e[2]);
    ax  = gx[W-1] ? -gx : gx;
    ay  = gy[W-1] ? -gy : gy;
    mag = ax + ay;
    if (mode_q) begin
      res = (mag >= {3'b000, thr_q}) ? '1 : '0;
    end else begin
      res = (|mag[W-1:PIXEL_WIDTH]) ? '1 : mag[PIXEL_WIDTH-1:0];
    end
  end

  // strip sequencing: fill, slide, drain
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && (strip_windows_i != '0)) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        if (px_acc) begin
          cnt_d = cnt_q + 4'd1;
          if (last_px) begin
            cnt_d   = '0;
            state_d = final_win ? S_DRAIN : S_SLIDE;
          end
        end
      end
      S_SLIDE: begin
        if (px_acc) begin
          cnt_d = cnt_q + 4'd1;
          if (last_px) begin
            cnt_d = '0;
            if (final_win) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((wl_q == '0) && ov_q && s.out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, window, config and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wl_q    <= '0;
      mode_q  <= 1'b0;
      thr_q   <= '0;
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
      opx_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wl_q    <= '0;
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= 1'b0;
      if ((state_q == S_IDLE) && start_i) begin
        if (strip_windows_i != '0) begin
          wl_q   <= strip_windows_i;
          mode_q <= mode_i;
          thr_q  <= threshold_i;
        end else begin
          done_q <= 1'b1;
        end
      end else if (out_load) begin
        wl_q <= wl_q - WIN_CNT_BITS'(1);
      end
      if (out_load) begin
        opx_q <= res;
        ov_q  <= 1'b1;
      end else if (ov_q && s.out_ready_i) begin
        ov_q  <= 1'b0;
      end
      if ((state_q == S_DRAIN) && (state_d == S_IDLE)) done_q <= 1'b1;
      if (px_acc) begin
        if (state_q == S_FILL) begin
          p_q[cnt_q] <= s.px_data_i;
        end else begin
          unique case (cnt_q)
            4'd0: begin
              p_q[0] <= p_q[3];
              p_q[1] <= p_q[4];
              p_q[2] <= p_q[5];
              p_q[3] <= p_q[6];
              p_q[4] <= p_q[7];
              p_q[5] <= p_q[8];
              p_q[6] <= s.px_data_i;
            end
            4'd1:    p_q[7] <= s.px_data_i;
            default: p_q[8] <= s.px_data_i;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_stream.sv
// Scoreboard bench for sobel_window_stream: directed strips,
// backpressure, abort, reset and empty-strip cases.
module tb_sobel_window_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mode = 1'b0;
  logic [9:0] nwin = '0;
  logic [7:0] thr = '0;
  logic       busy, done;

  sobel_window_stream_if #(.PIXEL_WIDTH(8)) sif();

  sobel_window_stream #(
    .PIXEL_WIDTH (8),
    .WIN_CNT_BITS(10)
  ) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .start_i        (start),
    .abort_i        (abort),
    .strip_windows_i(nwin),
    .mode_i         (mode),
    .threshold_i    (thr),
    .s              (sif),
    .busy_o         (busy),
    .strip_done_o   (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int acc_cnt = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_xfer = -10;
  int last_done = -10;

  task automatic chk(input string nm, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  // monitor: handshakes seen at negedge complete on the next posedge
  always @(negedge clk) begin
    cyc++;
    if (sif.out_valid_o && sif.out_ready_i) begin
      xfer_cnt++;
      last_xfer = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0d, required none",
                 sif.out_px_o);
      end else begin
        chk("result", int'(sif.out_px_o), exp_q.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      last_done = cyc;
    end
    if (sif.px_valid_i && sif.px_ready_o) acc_cnt++;
  end

  task automatic start_strip(input int n, input logic m,
                             input logic [7:0] t);
    nwin  = 10'(n);
    mode  = m;
    thr   = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] v);
    int n;
    n = 0;
    sif.px_valid_i = 1'b1;
    sif.px_data_i  = v;
    @(negedge clk);
    while (!sif.px_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sif.px_ready_o) begin
      tests++;
      fails++;
      $display("FAIL px_timeout: got ready 0, required 1");
    end
    @(posedge clk); #1;
    sif.px_valid_i = 1'b0;
  endtask

  task automatic send_row(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    send_px(a);
    send_px(b);
    send_px(c);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy || exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy %0d pending %0d, required 0 0",
               busy, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  int d0, a0, x0, hv;

  initial begin
    sif.px_valid_i  = 1'b0;
    sif.px_data_i   = '0;
    sif.out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_px_ready", sif.px_ready_o, 0);
    chk("rst_out_valid", sif.out_valid_o, 0);
    chk("rst_out_px", sif.out_px_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // flat window -> 0, done pulse one cycle after transfer
    d0 = done_cnt;
    start_strip(1, 1'b0, 8'd0);
    exp_q.push_back(0);
    repeat (9) send_px(8'd10);
    wait_idle();
    chk("flat_done_cnt", done_cnt - d0, 1);
    chk("flat_done_timing", last_done - last_xfer, 1);

    // vertical edge, saturated
    start_strip(1, 1'b0, 8'd0);
    exp_q.push_back(255);
    repeat (3) send_row(8'd0, 8'd0, 8'd255);
    wait_idle();

    // vertical edge, threshold 100
    start_strip(1, 1'b1, 8'd100);
    exp_q.push_back(255);
    repeat (3) send_row(8'd0, 8'd0, 8'd255);
    wait_idle();

    // flat window, threshold 0 -> edge
    start_strip(1, 1'b1, 8'd0);
    exp_q.push_back(255);
    repeat (9) send_px(8'd10);
    wait_idle();

    // flat window, threshold 1 -> no edge
    start_strip(1, 1'b1, 8'd1);
    exp_q.push_back(0);
    repeat (9) send_px(8'd10);
    wait_idle();

    // slide over 3 windows of a vertical ramp
    a0 = acc_cnt;
    d0 = done_cnt;
    start_strip(3, 1'b0, 8'd0);
    repeat (3) exp_q.push_back(8);
    for (int r = 1; r <= 5; r++) send_row(8'(r), 8'(r), 8'(r));
    wait_idle();
    chk("slide_accepted", acc_cnt - a0, 15);
    chk("slide_ready_after", sif.px_ready_o, 0);
    chk("slide_done_cnt", done_cnt - d0, 1);

    // backpressure: rows 0,1,3,6,10 -> 12,20,28
    a0 = acc_cnt;
    sif.out_ready_i = 1'b0;
    start_strip(3, 1'b0, 8'd0);
    exp_q.push_back(12);
    exp_q.push_back(20);
    exp_q.push_back(28);
    fork
      begin
        send_row(8'd0, 8'd0, 8'd0);
        send_row(8'd1, 8'd1, 8'd1);
        send_row(8'd3, 8'd3, 8'd3);
        send_row(8'd6, 8'd6, 8'd6);
        send_row(8'd10, 8'd10, 8'd10);
      end
      begin
        hv = 0;
        while (!sif.out_valid_o && hv < 100) begin
          @(negedge clk);
          hv++;
        end
        chk("bp_first_valid", sif.out_valid_o, 1);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("bp_hold_valid", sif.out_valid_o, 1);
          chk("bp_hold_px", sif.out_px_o, 12);
        end
        chk("bp_ready_low", sif.px_ready_o, 0);
        chk("bp_accepted", acc_cnt - a0, 12);
        @(posedge clk); #1;
        sif.out_ready_i = 1'b1;
      end
    join
    wait_idle();
    chk("bp_total_accepted", acc_cnt - a0, 15);

    // abort in SLIDE with a held output and a pending window
    sif.out_ready_i = 1'b0;
    d0 = done_cnt;
    x0 = xfer_cnt;
    start_strip(3, 1'b0, 8'd0);
    send_row(8'd0, 8'd0, 8'd0);
    send_row(8'd1, 8'd1, 8'd1);
    send_row(8'd3, 8'd3, 8'd3);
    send_row(8'd6, 8'd6, 8'd6);
    @(negedge clk);
    chk("ab_pre_valid", sif.out_valid_o, 1);
    chk("ab_pre_ready", sif.px_ready_o, 0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("ab_busy", busy, 0);
    chk("ab_valid", sif.out_valid_o, 0);
    chk("ab_ready", sif.px_ready_o, 0);
    @(posedge clk); #1;
    sif.out_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("ab_no_done", done_cnt - d0, 0);
    chk("ab_no_xfer", xfer_cnt - x0, 0);
    @(posedge clk); #1;
    a0 = acc_cnt;
    start_strip(1, 1'b0, 8'd0);
    exp_q.push_back(255);
    repeat (3) send_row(8'd0, 8'd0, 8'd255);
    wait_idle();
    chk("ab_refill_accepted", acc_cnt - a0, 9);
    chk("ab_refill_done", done_cnt - d0, 1);

    // asynchronous reset in FILL
    start_strip(1, 1'b0, 8'd0);
    repeat (4) send_px(8'd10);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_px_ready", sif.px_ready_o, 0);
    chk("ar_out_valid", sif.out_valid_o, 0);
    chk("ar_out_px", sif.out_px_o, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    x0 = xfer_cnt;
    repeat (10) @(negedge clk);
    chk("ar_no_output", xfer_cnt - x0, 0);
    chk("ar_idle", busy, 0);
    @(posedge clk); #1;

    // empty strip: single done pulse, no output
    d0 = done_cnt;
    start_strip(0, 1'b0, 8'd0);
    repeat (5) @(negedge clk);
    chk("empty_done_cnt", done_cnt - d0, 1);
    chk("empty_no_output", xfer_cnt - x0, 0);
    chk("empty_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sobel_window_stream.md
# sobel_window_stream

Parametrised Sobel window controller with a full valid/ready stream interface. It collects 3x3 windows from a serial pixel stream and computes the gradient magnitude internally. Output is either a saturated magnitude or a thresholded binary edge, selected at run time. It sits between the grayscale converter and the output formatter and covers a vertical strip of a configurable number of windows, with backpressure, abort and strip-done signalling.

## Interface
- PIXEL_WIDTH, 8: unsigned pixel width for both input and output.
- WIN_CNT_BITS, 10: width of the window-count input; a strip holds at most 2^WIN_CNT_BITS-1 windows.
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous reset, active-high.
- start_i  in  1  begins a strip when in IDLE; ignored otherwise.
- abort_i  in  1  returns to IDLE on the next edge from any state.
- strip_windows_i  in  WIN_CNT_BITS  number of windows in the strip; latched at start.
- mode_i  in  1  0 = saturated magnitude, 1 = threshold; latched at start.
- threshold_i  in  PIXEL_WIDTH  threshold value; latched at start.
- px_valid_i  in  1  input pixel valid.
- px_data_i  in  PIXEL_WIDTH  input pixel.
- px_ready_o  out  1  block accepts a pixel (combinational).
- out_valid_o  out  1  result valid.
- out_px_o  out  PIXEL_WIDTH  result pixel.
- out_ready_i  in  1  downstream accepts the result.
- busy_o  out  1  state is not IDLE.
- strip_done_o  out  1  one-cycle pulse at strip end.

## Operation
- A pixel is accepted when px_valid_i && px_ready_o. A result is transferred when out_valid_o && out_ready_i.
- Window registers p0..p8 are row-major; p0..p2 is the top row. Pixels arrive row by row, left to right.
- States and transitions:
  - IDLE: on start_i with strip_windows_i != 0, latch configuration, set windows_left = strip_windows_i and go to FILL.
  - IDLE: on start_i with strip_windows_i == 0, stay in IDLE and pulse strip_done_o on the next cycle.
  - FILL: accepted pixels load p0..p8 in order. The 9th pixel sets win_pending and moves to SLIDE; if windows_left == 1 it moves to DRAIN instead.
  - SLIDE: the 1st accepted pixel shifts rows up (p0..p2 <= p3..p5, p3..p5 <= p6..p8) and loads p6. The 2nd pixel loads p7. The 3rd loads p8, sets win_pending, and moves to DRAIN if this is the final window.
  - DRAIN: wait until the final result is transferred, then pulse strip_done_o and go to IDLE.
- out_load = win_pending && (!out_valid_o || out_ready_i).
  - On out_load: the output register captures the result, out_valid_o is set, win_pending clears and windows_left decrements.
- px_ready_o = (state is FILL or SLIDE) && (!win_pending || out_load).
  - A pixel may be accepted on the same edge the pending window moves to the output register.
  - While the window is pending and cannot move, no pixel is accepted.
- Arithmetic:
  - Gx = (p2+2p5+p8) - (p0+2p3+p6).
  - Gy = (p6+2p7+p8) - (p0+2p1+p2).
  - Both are signed, PIXEL_WIDTH+3 bits.
  - mag = |Gx|+|Gy|, unsigned, PIXEL_WIDTH+3 bits; no overflow is possible.
- Output value:
  - mode 0: out = min(mag, 2^PIXEL_WIDTH-1).
  - mode 1: out = all-ones if mag >= threshold (zero-extended), else 0.
- out_px_o and out_valid_o are held stable while out_valid_o && !out_ready_i.
- abort_i takes priority over all other inputs. The next edge sets IDLE and clears win_pending, out_valid_o, windows_left and p0..p8; strip_done_o is not pulsed.

## Timing
- Reset values: px_ready_o 0, out_valid_o 0, out_px_o 0, busy_o 0, strip_done_o 0. All window registers, counters and latched configuration are 0.
- Latency: the window-completing pixel is accepted at edge N. With downstream ready, out_valid_o is high after edge N+1.
- Throughput:
  - One result per 3 accepted pixels in SLIDE, with no bubble.
  - The first window of a strip needs 9 pixels.
- strip_done_o is high for the single cycle after the edge on which the final result transferred.
- start_i while busy_o is high has no effect.
- Reset mid-strip: all registers clear immediately and asynchronously; nothing is output after reset release until a new start_i.

## Test plan
- Flat window: start, strip_windows_i=1, mode 0; 9 pixels of value 10 -> one result 0, strip_done_o pulses one cycle after the transfer.
- Vertical edge: three rows (0,0,255), mode 0 -> 255 (mag 1020 saturated). Same window in mode 1 with threshold 100 -> 255; threshold 0 on a flat window -> 255.
- Slide: strip_windows_i=3, rows (1,1,1),(2,2,2),(3,3,3),(4,4,4),(5,5,5) -> three results of 8. Exactly 15 pixels are accepted, px_ready_o low afterwards.
- Backpressure: out_ready_i held low for 10 cycles.
  - out_px_o and out_valid_o stay stable.
  - px_ready_o drops once the next window completes.
  - Releasing out_ready_i resumes the stream with no lost or duplicated result.
- Abort mid-SLIDE with a pending output -> IDLE on the next edge, out_valid_o 0, no strip_done_o. A following start runs a clean FILL.
- reset_i asserted mid-FILL -> all outputs 0 asynchronously. start_i with strip_windows_i=0 -> no output, single strip_done_o pulse.
